// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, starvation
// limit, counter width and the auxiliary handshake state encoding.
package dmem_arbiter_pkg;

  localparam int unsigned DATA_W_DEF       = 16;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned CNT_W            = 4;

  typedef enum logic {
    A_IDLE = 1'b0,
    A_ACK  = 1'b1
  } aux_state_e;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU memory stage, the auxiliary requester, the data
// memory and the arbiter.
//   slave  : arbiter view (CPU/aux requests and mem_rdata in; grants, strobes,
//            stall, ack and read data out)
//   master : environment view (CPU, auxiliary requester and dmem)
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  // CPU memory stage
  logic              cpu_rd;
  logic              cpu_wr;
  logic [DATA_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  // Auxiliary requester (DMA / debug loader)
  logic              aux_req;
  logic              aux_we;
  logic [DATA_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic              aux_ack;
  logic [DATA_W-1:0] aux_rdata;

  // Single-port data memory
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_ack, aux_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_ack, aux_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface : dmem_arbiter_if

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating count of consecutive denied auxiliary-request cycles.
//   clk, reset   : clock, asynchronous active-low reset
//   clr_i        : clear to zero (auxiliary grant), dominates en_i
//   en_i         : count one denied cycle, saturating at LIMIT
//   at_limit_o   : counter has reached LIMIT
module dmem_arbiter_starve_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic at_limit_o
);

  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT_V)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT_V);

endmodule : dmem_arbiter_starve_counter

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU memory stage
// (priority, zero-latency, combinational stall) and an auxiliary requester
// (registered req/ack handshake, wait bounded by STARVE_LIMIT).
//   clk, reset : clock, asynchronous active-low reset
//   bus        : slave view of dmem_arbiter_if (CPU, auxiliary and dmem sides)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  aux_state_e        state_q;
  aux_state_e        state_d;
  logic [DATA_W-1:0] aux_rdata_q;
  logic [DATA_W-1:0] aux_rdata_d;

  logic cpu_req;
  logic aux_elig;
  logic aux_gnt;
  logic cpu_gnt;
  logic at_limit;

  // Grant decision; qualifying with reset keeps strobes and stall low while
  // reset is held, even though the state is already forced idle.
  always_comb begin
    cpu_req  = bus.cpu_rd | bus.cpu_wr;
    aux_elig = reset & bus.aux_req & (state_q == A_IDLE);
    aux_gnt  = aux_elig & (~cpu_req | at_limit);
    cpu_gnt  = reset & cpu_req & ~aux_gnt;
  end

  dmem_arbiter_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (aux_gnt),
    .en_i       (aux_elig & ~aux_gnt),
    .at_limit_o (at_limit)
  );

  // Auxiliary handshake FSM and read-data capture.
  always_comb begin
    state_d     = state_q;
    aux_rdata_d = aux_rdata_q;
    case (state_q)
      A_IDLE: if (aux_gnt) state_d = A_ACK;
      A_ACK:  state_d = A_IDLE;
      default: state_d = A_IDLE;
    endcase
    if (aux_gnt && !bus.aux_we) begin
      aux_rdata_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= A_IDLE;
      aux_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  // Memory-side mux; simultaneous cpu_rd and cpu_wr is treated as a write.
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (aux_gnt) begin
      bus.mem_rd    = ~bus.aux_we;
      bus.mem_wr    = bus.aux_we;
      bus.mem_addr  = bus.aux_addr;
      bus.mem_wdata = bus.aux_wdata;
    end else if (cpu_gnt) begin
      bus.mem_rd    = bus.cpu_rd & ~bus.cpu_wr;
      bus.mem_wr    = bus.cpu_wr;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.cpu_stall = cpu_req & aux_gnt;
  assign bus.aux_ack   = (state_q == A_ACK);
  assign bus.aux_rdata = aux_rdata_q;

endmodule : dmem_arbiter

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the CPU's memory stage and an auxiliary requester (DMA/debug loader), so test images can be preloaded and results dumped without a second memory port. It sits between `cpu` and `dmem` inside `top`. The CPU has priority, and a starvation counter bounds the auxiliary requester's wait. The CPU sees a combinational stall; the auxiliary port uses a registered request/ack handshake.

## Interface
Parameters:
- `DATA_W`, 16: data and address width.
- `STARVE_LIMIT`, 4: consecutive denied auxiliary-request cycles before the auxiliary requester wins one slot. Legal range 1..15.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_rd`, `cpu_wr` in 1 each: CPU memory-stage read and write strobes.
- `cpu_addr`, `cpu_wdata` in DATA_W each.
- `cpu_rdata` out DATA_W: `mem_rdata` passed through combinationally.
- `cpu_stall` out 1: CPU access not performed this cycle; the CPU holds its memory-stage values.
- `aux_req` in 1: auxiliary request. Held with `aux_we`, `aux_addr` and `aux_wdata` stable until `aux_ack`.
- `aux_we` in 1: 1 = write, 0 = read.
- `aux_addr`, `aux_wdata` in DATA_W each.
- `aux_ack` out 1: one-cycle completion pulse.
- `aux_rdata` out DATA_W: registered read data; valid while `aux_ack`=1 and held until the next auxiliary read completes.
- `mem_rd`, `mem_wr` out 1 each: strobes to `dmem`.
- `mem_addr`, `mem_wdata` out DATA_W each: address and write data to `dmem`.
- `mem_rdata` in DATA_W: combinational read data from `dmem`.

## Operation
- Auxiliary FSM, 2 states:
  - A_IDLE: auxiliary requests may be granted.
  - A_ACK: the auxiliary requester was granted last cycle. No auxiliary grant is allowed in this state.
  - A_IDLE -> A_ACK on `aux_gnt`. A_ACK -> A_IDLE unconditionally.
- `cpu_req = cpu_rd | cpu_wr`.
- `cpu_rd` and `cpu_wr` both high is a write: `mem_wr`=1 and `mem_rd`=0.
- `aux_elig = aux_req & (state == A_IDLE)`.
- `aux_gnt = aux_elig & (~cpu_req | starve_cnt == STARVE_LIMIT)`.
- `cpu_gnt = cpu_req & ~aux_gnt`.
- `cpu_stall = cpu_req & aux_gnt`.
- Memory-side mux, combinational:
  - On `aux_gnt`, drive the auxiliary address and data; `mem_wr = aux_we`, `mem_rd = ~aux_we`.
  - On `cpu_gnt`, drive the CPU address, data and strobes.
  - Otherwise both strobes are 0, and address and data are 0.
- Starvation counter `starve_cnt` (4 bits), per rising edge:
  - Clears to 0 on `aux_gnt`.
  - Increments when `aux_elig & ~aux_gnt`, saturating at STARVE_LIMIT.
  - Otherwise holds.
- On `aux_gnt` with `aux_we`=0, `aux_rdata` captures `mem_rdata` at the edge.
- `aux_ack` is registered: it equals 1 exactly in the A_ACK cycle.
- The auxiliary requester may hold `aux_req` high through the ack cycle for back-to-back transfers. The next grant comes no earlier than the cycle after the ack, so the maximum rate is one auxiliary transfer per 2 cycles.

## Timing
- CPU path latency is 0 cycles: the grant, memory strobes and `cpu_rdata` all occur in the request cycle. Writes commit at `dmem`'s next rising edge.
- Auxiliary path: the grant is in cycle N and `aux_ack`/`aux_rdata` are valid in cycle N+1.
- Worst-case auxiliary wait under continuous CPU traffic is STARVE_LIMIT cycles from request to grant.
- The CPU is stalled at most 1 cycle per STARVE_LIMIT+2 cycles.
- While `reset`=0:
  - State is A_IDLE, `starve_cnt`=0, `aux_ack`=0, `aux_rdata`=0.
  - `mem_rd`, `mem_wr` and `cpu_stall` are forced to 0 combinationally.
- Reset mid-operation:
  - An auxiliary transfer that was granted but not yet acked is dropped; no ack is issued.
  - A write whose edge coincides with reset assertion is not guaranteed to commit.
- Auxiliary request withdrawn before grant: no transfer, and `starve_cnt` holds its value.
- `aux_req` dropped during A_ACK: no effect on the ack.

## Structure
- Shared include header (alongside `opcodes.v`) holds:
  - the A_IDLE and A_ACK encodings;
  - the default DATA_W and STARVE_LIMIT.
- One sub-module, `starve_counter`: saturating counter with clear, enable and limit compare; its output is `at_limit`.
- The grant logic and memory mux stay in `dmem_arbiter`.

## Test plan
- CPU write alone, `cpu_addr`=0 and `cpu_wdata`=5 -> same cycle `mem_wr`=1, `mem_addr`=0, `mem_wdata`=5, `cpu_stall`=0. A following CPU read of addr 0 returns 5 on `cpu_rdata`.
- CPU idle, auxiliary read of addr 4 after preloading 15 -> grant in cycle N, `aux_ack`=1 in cycle N+1 with `aux_rdata`=15. `aux_ack` is 0 in cycle N+2.
- CPU writes every cycle, `aux_req` (write addr 6, data 0xFFF1) raised at cycle 0 with STARVE_LIMIT=4 -> auxiliary granted at cycle 4 with `cpu_stall`=1 in cycle 4 only; `aux_ack` at cycle 5; memory at addr 6 = 0xFFF1.
- `aux_req` held continuously with CPU idle -> grants at cycles 0, 2, 4 and acks at 1, 3, 5, with no duplicate transfer.
- `cpu_rd`=`cpu_wr`=1, addr 2, data 5 -> `mem_wr`=1, `mem_rd`=0, and addr 2 = 5.
- Auxiliary granted at cycle N, `reset` low during cycle N -> no `aux_ack`, `aux_rdata`=0, strobes 0. After release the arbiter is back in A_IDLE with `starve_cnt`=0.
